// File: rtl/queue_param.sv
// Parametrised circular-buffer queue with occupancy flags and sticky error flags.
// Optional LIFO mode is compiled in with the QUEUE_PARAM_LIFO_EN macro.
module queue_param #(
  parameter int DATA_W   = 4,
  parameter int DEPTH    = 8,
  parameter int AF_LEVEL = DEPTH - 1,
  parameter int AE_LEVEL = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         enable,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         flush,
`ifdef QUEUE_PARAM_LIFO_EN
  input  logic                         lifo,
`endif
  input  logic [DATA_W-1:0]            data_in,
  output logic [DATA_W-1:0]            data_out,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty,
  output logic                         almost_full,
  output logic                         almost_empty,
  output logic                         overflow,
  output logic                         underflow
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_C    = CNT_W'(AF_LEVEL);
  localparam logic [CNT_W-1:0] AE_C    = CNT_W'(AE_LEVEL);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic              mode_q, mode_d;

  logic              is_empty, is_full;
  logic              accept, pop_ok, push_ok;
  logic              lifo_op;
  logic [PTR_W-1:0]  top_ptr, wr_addr, rd_addr;

  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == DEPTH_C);
  assign top_ptr  = PTR_W'(count_q) - 1'b1;

`ifdef QUEUE_PARAM_LIFO_EN
  // The mode may only change while the queue is empty, and an operation on an
  // empty queue already follows the newly requested mode.
  assign lifo_op = is_empty ? lifo : mode_q;
  assign mode_d  = (enable && is_empty) ? lifo : mode_q;
`else
  assign lifo_op = 1'b0;
  assign mode_d  = 1'b0;
`endif

  always_comb begin
    accept  = enable & ~flush;
    pop_ok  = accept & pop & ~is_empty;
    push_ok = accept & push & (~is_full | pop_ok);

    // LIFO push+pop overwrites the current top instead of stacking above it.
    if (lifo_op) begin
      wr_addr = pop_ok ? top_ptr : PTR_W'(count_q);
    end else begin
      wr_addr = wr_ptr_q;
    end

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q | (accept & push & ~push_ok);
    unf_d    = unf_q | (accept & pop & is_empty);

    if (!lifo_op) begin
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
      unf_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      mode_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      mode_q   <= mode_d;
    end
  end

  // Storage carries no reset; only the control state above is cleared.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_addr] <= data_in;
  end

  assign rd_addr      = mode_q ? top_ptr : rd_ptr_q;
  assign data_out     = is_empty ? '0 : mem_q[rd_addr];
  assign count        = count_q;
  assign full         = is_full;
  assign empty        = is_empty;
  assign almost_full  = (count_q >= AF_C);
  assign almost_empty = (count_q <= AE_C);
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

endmodule

// File: tb/tb_queue_param.sv
// Scoreboard bench for queue_param: a reference queue predicts contents and flags.
module tb_queue_param;

  localparam int DATA_W = 4;
  localparam int DEPTH  = 8;
  localparam int CNT_W  = $clog2(DEPTH + 1);

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              enable = 1'b0;
  logic              push = 1'b0;
  logic              pop = 1'b0;
  logic              flush = 1'b0;
  logic [DATA_W-1:0] data_in = '0;
  logic [DATA_W-1:0] data_out;
  logic [CNT_W-1:0]  count;
  logic              full, empty, almost_full, almost_empty, overflow, underflow;
`ifdef QUEUE_PARAM_LIFO_EN
  logic              lifo = 1'b0;
`endif

  int checks   = 0;
  int failures = 0;

  int sb[$];
  bit m_ovf = 1'b0;
  bit m_unf = 1'b0;
  bit m_lifo = 1'b0;

  always #5 clk = ~clk;

  queue_param #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .enable(enable), .push(push), .pop(pop),
    .flush(flush),
`ifdef QUEUE_PARAM_LIFO_EN
    .lifo(lifo),
`endif
    .data_in(data_in), .data_out(data_out), .count(count), .full(full),
    .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
    .overflow(overflow), .underflow(underflow)
  );

  task automatic check_val(string tag, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", tag, act, exp);
    end
  endtask

  function automatic int exp_head();
    if (sb.size() == 0) return 0;
    return m_lifo ? sb[$] : sb[0];
  endfunction

  task automatic check_state(string tag);
    int n = sb.size();
    check_val({tag, ".count"}, 32'(count), n);
    check_val({tag, ".full"},  32'(full),  (n == DEPTH) ? 1 : 0);
    check_val({tag, ".empty"}, 32'(empty), (n == 0) ? 1 : 0);
    check_val({tag, ".af"},    32'(almost_full),  (n >= DEPTH - 1) ? 1 : 0);
    check_val({tag, ".ae"},    32'(almost_empty), (n <= 1) ? 1 : 0);
    check_val({tag, ".ovf"},   32'(overflow),  32'(m_ovf));
    check_val({tag, ".unf"},   32'(underflow), 32'(m_unf));
    check_val({tag, ".dout"},  32'(data_out),  exp_head());
  endtask

  // One clock of stimulus: predict, compare popped word before the edge,
  // then compare full state after the edge.
  task automatic step(string tag, bit ps, bit pp, int d, bit en = 1'b1, bit fl = 1'b0);
    bit pop_ok, push_ok, op_lifo;
    @(negedge clk);
    push = ps; pop = pp; data_in = DATA_W'(d); enable = en; flush = fl;
    op_lifo = m_lifo;
`ifdef QUEUE_PARAM_LIFO_EN
    if (en && sb.size() == 0) begin
      op_lifo = lifo;
      m_lifo  = lifo;
    end
`endif
    if (fl) begin
      sb.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else if (en) begin
      pop_ok  = pp && (sb.size() > 0);
      push_ok = ps && ((sb.size() < DEPTH) || pop_ok);
      if (ps && !push_ok) m_ovf = 1'b1;
      if (pp && sb.size() == 0) m_unf = 1'b1;
      if (pop_ok) begin
        if (op_lifo) begin
          check_val({tag, ".popword"}, 32'(data_out), sb[$]);
          void'(sb.pop_back());
        end else begin
          check_val({tag, ".popword"}, 32'(data_out), sb[0]);
          void'(sb.pop_front());
        end
      end
      if (push_ok) sb.push_back(d);
    end
    @(posedge clk);
    #1;
    check_state(tag);
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_state("reset");
    @(negedge clk);
    reset = 1'b1;
    enable = 1'b1;

    // Fill to full, then one rejected push
    for (int i = 1; i <= 8; i++) step($sformatf("fill%0d", i), 1, 0, i);
    step("push_full", 1, 0, 9);

    // Drain in order, then one rejected pop
    for (int i = 1; i <= 8; i++) step($sformatf("drain%0d", i), 0, 1, 0);
    step("pop_empty", 0, 1, 0);

    // Pointer wrap
    step("flush0", 0, 0, 0, 1, 1);
    for (int i = 0; i < 6; i++) step("wrap_push6", 1, 0, i + 1);
    for (int i = 0; i < 6; i++) step("wrap_pop6", 0, 1, 0);
    for (int i = 0; i < 5; i++) step("wrap_pushAE", 1, 0, 10 + i);
    for (int i = 0; i < 5; i++) step("wrap_popAE", 0, 1, 0);

    // Simultaneous push+pop at full and at empty
    step("flush1", 0, 0, 0, 1, 1);
    for (int i = 1; i <= 8; i++) step("sim_fill", 1, 0, i);
    step("sim_full", 1, 1, 15);
    for (int i = 0; i < 8; i++) step("sim_drain", 0, 1, 0);
    step("sim_empty", 1, 1, 3);

    // Enable gating, flush with overflow set
    for (int i = 0; i < 3; i++) step("disabled", 1, 1, 7, 0);
    step("flush2", 0, 0, 0, 1, 1);
    for (int i = 1; i <= 8; i++) step("ctl_fill", 1, 0, i);
    step("ctl_ovf", 1, 0, 5);
    for (int i = 0; i < 3; i++) step("ctl_pop", 0, 1, 0);
    step("flush_ovf", 1, 1, 6, 1, 1);
    for (int i = 0; i < 4; i++) step("burst", 1, 0, 4 + i);

    // Asynchronous reset between edges
    @(negedge clk);
    push = 1'b1; data_in = 4'd9;
    #2 reset = 1'b0;
    #1;
    sb.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
    m_lifo = 1'b0;
    check_state("async_rst");
    @(negedge clk);
    push = 1'b0;
    reset = 1'b1;
    step("post_rst", 1, 0, 2);
    step("post_rst_pop", 0, 1, 0);

`ifdef QUEUE_PARAM_LIFO_EN
    lifo = 1'b1;
    for (int i = 1; i <= 3; i++) step("lifo_push", 1, 0, i);
    check_val("lifo_top", 32'(data_out), 3);
    step("lifo_pop", 0, 1, 0);
    check_val("lifo_next", 32'(data_out), 2);
    lifo = 1'b0;
    step("lifo_hold", 1, 0, 4);
    step("lifo_swap", 1, 1, 9);
    for (int i = 0; i < 3; i++) step("lifo_drain", 0, 1, 0);
    step("lifo_unf", 0, 1, 0);
    step("fifo_back1", 1, 0, 5);
    step("fifo_back2", 1, 0, 6);
    step("fifo_back_pop", 0, 1, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/queue_param.md
Name: queue_param

Overview:
Parametrised synchronous queue. Generalises the fixed 4-bit x 8 shift queue to a circular-buffer FIFO of configurable width and depth. Adds an occupancy count, almost-full/almost-empty thresholds, simultaneous push+pop, flush, and sticky overflow/underflow error flags. Serves as a general staging buffer between producer and consumer blocks in the practice designs.

Parameters:
DATA_W, 4, data word width in bits
DEPTH, 8, number of entries; power of two, >= 2
AF_LEVEL, DEPTH-1, almost_full asserts when count >= AF_LEVEL (1..DEPTH)
AE_LEVEL, 1, almost_empty asserts when count <= AE_LEVEL (0..DEPTH-1)
(localparam CNT_W = $clog2(DEPTH+1); PTR_W = $clog2(DEPTH))

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset
enable  input  1  gates push/pop; 0 = hold all state
push  input  1  write request
pop  input  1  read request
flush  input  1  synchronous clear of contents, independent of enable
data_in  input  DATA_W  write data
data_out  output  DATA_W  head entry, first-word-fall-through; 0 when empty
count  output  CNT_W  current occupancy, 0..DEPTH
full  output  1  count == DEPTH
empty  output  1  count == 0
almost_full  output  1  count >= AF_LEVEL
almost_empty  output  1  count <= AE_LEVEL
overflow  output  1  sticky: push rejected because full
underflow  output  1  sticky: pop rejected because empty

Behaviour:
- Reset (async, active-low):
  - wr_ptr = rd_ptr = 0, count = 0.
  - Outputs: data_out 0, empty 1, full 0, almost_empty 1, almost_full 0, overflow 0, underflow 0.
  - Storage array is not reset.
  - Reset mid-operation discards all contents immediately.
- Priority per rising edge: flush > enable-gated push/pop.
- flush = 1: pointers and count go to 0; overflow and underflow clear; any push/pop in the same cycle is ignored. Storage is untouched.
- enable = 0 (and no flush): all state holds; no error flags set.
- pop_ok = pop & !empty.
- push_ok = push & (!full | pop_ok).
- push_ok: mem[wr_ptr] <= data_in; wr_ptr increments modulo DEPTH (natural wrap).
- pop_ok: rd_ptr increments modulo DEPTH.
- Count update:
  - push_ok only: count + 1
  - pop_ok only: count - 1
  - both: count unchanged
- Push + pop when full: both accepted, count stays DEPTH, no overflow.
- Push + pop when empty: push accepted; pop rejected and underflow set; count becomes 1.
- Error flags (only when enable = 1):
  - push & !push_ok sets overflow.
  - pop & empty sets underflow.
  - Both are sticky until reset or flush.
- data_out = empty ? 0 : mem[rd_ptr]; combinational from registers.
- Latency: a word pushed into an empty queue appears on data_out after the same edge that writes it.
- All flags are combinational decodes of the count register; no extra latency.

Optional Feature:
Macro QUEUE_PARAM_LIFO_EN.
- Defined:
  - Adds input port lifo (1 bit) and an internal mode register, reset to 0 (FIFO).
  - The mode register loads lifo on any enabled edge where count == 0; otherwise lifo is ignored.
  - In LIFO mode: push writes mem[count]; pop removes entry count-1; data_out = mem[count-1] (0 when empty).
  - Push + pop in LIFO mode overwrites the top entry; count unchanged.
  - Flags and error rules are identical to FIFO mode.
- Undefined: no lifo port; FIFO only.

Test Plan:
1. Defaults. Reset, push 1..8 -> full=1, count=8, almost_full=1 at count 7; data_out=1. Push 9 -> rejected, overflow=1, data_out still 1.
2. Pop 8 times from full -> data_out sequence 1,2,...,8 then 0; empty=1. Extra pop -> underflow=1, count stays 0.
3. Wrap. Push 6, pop 6, push 5 (A..E), pop 5 -> order A..E, pointers wrap past 7 correctly.
4. Simultaneous. Full queue holding 1..8, push=pop=1 with data_in=F -> count 8, data_out=2, no overflow. Empty queue, push=pop=1 with data_in=3 -> count 1, data_out=3, underflow=1.
5. Control. enable=0 with push=1 for 3 cycles -> no change. flush with count=5 and overflow=1 -> count 0, overflow 0, empty 1. Async reset mid-burst -> outputs return to reset values immediately.
6. With QUEUE_PARAM_LIFO_EN. lifo=1 while empty, push 1,2,3 -> data_out=3; pop -> 2. lifo=0 while count=2 -> mode stays LIFO.
